// File: rtl/wrr_pkg.sv
// wrr_pkg -- shared constants for the weighted round-robin pop scheduler.
//   - FSM state encoding (IDLE=0, WAIT=1, SEND=2)
//   - default parameter values used by wrr_pop_scheduler / wrr_slot_select
package wrr_pkg;

   localparam int DEF_QUEUE_QUANTITY = 4;
   localparam int DEF_DATA_BITS      = 8;
   localparam int DEF_MAX_WEIGHT     = 64;
   localparam int DEF_TABLE_SIZE     = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_SEND = 2'd2;

endpackage

// File: rtl/wrr_slot_select.sv
// wrr_slot_select -- combinational slot search for the WRR scheduler.
// A slot is eligible when its queue is non-empty and has non-zero weight.
// Build option: WRR_WORK_CONSERVING_EN
//   undefined : only the slot at ptr is examined (sel_slot = ptr)
//   defined   : first eligible slot at or after ptr, wrapping
// Ports:
//   ptr       in  current slot pointer
//   tabla     in  slot -> queue table (QB bits per slot)
//   pesos     in  per-queue weights (WB bits per queue)
//   buf_empty in  per-queue FIFO empty flags
//   sel_slot  out selected slot
//   sel_queue out queue index of the selected slot
//   hit       out selected slot is eligible
module wrr_slot_select #(
   parameter int QUEUE_QUANTITY = 4,
   parameter int TABLE_SIZE     = 8,
   parameter int WB             = 6,
   parameter int QB             = 2,
   parameter int PB             = 3
) (
   input  logic [PB-1:0]                ptr,
   input  logic [TABLE_SIZE*QB-1:0]     tabla,
   input  logic [QUEUE_QUANTITY*WB-1:0] pesos,
   input  logic [QUEUE_QUANTITY-1:0]    buf_empty,
   output logic [PB-1:0]                sel_slot,
   output logic [QB-1:0]                sel_queue,
   output logic                         hit
);

   logic [TABLE_SIZE-1:0] elig;

   for (genvar s = 0; s < TABLE_SIZE; s++) begin : g_slot
      logic [QB-1:0] q;
      assign q       = tabla[s*QB +: QB];
      assign elig[s] = ~buf_empty[q] & (pesos[q*WB +: WB] != '0);
   end

`ifdef WRR_WORK_CONSERVING_EN
   // Scan from farthest to nearest so the nearest eligible slot wins.
   always_comb begin
      int idx;
      idx      = 0;
      sel_slot = ptr;
      hit      = 1'b0;
      for (int k = TABLE_SIZE - 1; k >= 0; k--) begin
         idx = int'(ptr) + k;
         if (idx >= TABLE_SIZE) idx = idx - TABLE_SIZE;
         if (elig[idx]) begin
            sel_slot = PB'(idx);
            hit      = 1'b1;
         end
      end
   end
`else
   assign sel_slot = ptr;
   assign hit      = elig[ptr];
`endif

   assign sel_queue = tabla[sel_slot*QB +: QB];

endmodule

// File: rtl/wrr_pop_scheduler.sv
// wrr_pop_scheduler -- weighted round-robin reader over QUEUE_QUANTITY FIFOs.
// A table of TABLE_SIZE slots names a queue per slot; each slot is served
// pesos[q] times before the pointer moves on. FIFO read latency is 1 cycle;
// at most one word is in flight, so peak rate is one word per 2 cycles.
// Build option: WRR_WORK_CONSERVING_EN (skip ineligible slots without idling).
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   enb        scheduler enable (0 freezes everything, pop=0)
//   pesos      per-queue weight, queue n at [(n+1)*WB-1:n*WB]
//   tabla      per-slot queue index, slot s at [(s+1)*QB-1:s*QB]
//   buf_empty  per-FIFO empty
//   fifo_data  per-FIFO registered read data
//   pop        one-hot FIFO read strobe
//   out_data / out_valid / out_queue / out_ready  output handshake
module wrr_pop_scheduler
   import wrr_pkg::*;
#(
   parameter int  QUEUE_QUANTITY = DEF_QUEUE_QUANTITY,
   parameter int  DATA_BITS      = DEF_DATA_BITS,
   parameter int  MAX_WEIGHT     = DEF_MAX_WEIGHT,
   parameter int  TABLE_SIZE     = DEF_TABLE_SIZE,
   localparam int WB = $clog2(MAX_WEIGHT),
   localparam int QB = (QUEUE_QUANTITY > 1) ? $clog2(QUEUE_QUANTITY) : 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                enb,
   input  logic [QUEUE_QUANTITY*WB-1:0]        pesos,
   input  logic [TABLE_SIZE*QB-1:0]            tabla,
   input  logic [QUEUE_QUANTITY-1:0]           buf_empty,
   input  logic [QUEUE_QUANTITY*DATA_BITS-1:0] fifo_data,
   output logic [QUEUE_QUANTITY-1:0]           pop,
   output logic [DATA_BITS-1:0]                out_data,
   output logic                                out_valid,
   output logic [QB-1:0]                       out_queue,
   input  logic                                out_ready
);

   localparam int PB = (TABLE_SIZE > 1) ? $clog2(TABLE_SIZE) : 1;

   logic [1:0]    state;
   logic [PB-1:0] ptr;
   logic [WB-1:0] cred;
   logic [QB-1:0] pend_q;

   logic [PB-1:0] sel_slot, nxt_slot;
   logic [QB-1:0] sel_queue, nxt_q, q0;
   logic          hit, xfer, try_pop;
   logic [WB-1:0] sel_w, nxt_w, w0, eff_cred;

   wrr_slot_select #(
      .QUEUE_QUANTITY(QUEUE_QUANTITY), .TABLE_SIZE(TABLE_SIZE),
      .WB(WB), .QB(QB), .PB(PB)
   ) u_sel (
      .ptr(ptr), .tabla(tabla), .pesos(pesos), .buf_empty(buf_empty),
      .sel_slot(sel_slot), .sel_queue(sel_queue), .hit(hit)
   );

   assign xfer    = (state == ST_SEND) && out_valid && out_ready;
   assign try_pop = enb && hit && ((state == ST_IDLE) || xfer);

   // Staying on the current slot keeps its running credit; landing on a new
   // slot (work-conserving jump) enters it fresh with its current weight.
   assign sel_w    = pesos[sel_queue*WB +: WB];
   assign eff_cred = (sel_slot == ptr) ? cred : sel_w - 1'b1;

   assign nxt_slot = (sel_slot == PB'(TABLE_SIZE - 1)) ? '0 : sel_slot + 1'b1;
   assign nxt_q    = tabla[nxt_slot*QB +: QB];
   assign nxt_w    = pesos[nxt_q*WB +: WB];

   assign q0 = tabla[QB-1:0];
   assign w0 = pesos[q0*WB +: WB];

   always_comb begin
      pop = '0;
      if (try_pop && !rst) pop[sel_queue] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= ST_IDLE;
         ptr       <= '0;
         cred      <= w0 - 1'b1;
         pend_q    <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_queue <= '0;
      end else if (enb) begin
         if (try_pop) begin
            pend_q <= sel_queue;
            if (eff_cred == '0) begin
               ptr  <= nxt_slot;
               cred <= nxt_w - 1'b1;
            end else begin
               ptr  <= sel_slot;
               cred <= eff_cred - 1'b1;
            end
         end
`ifndef WRR_WORK_CONSERVING_EN
         // Ineligible slot while idle: burn this cycle, then move on.
         else if (state == ST_IDLE) begin
            ptr  <= nxt_slot;
            cred <= nxt_w - 1'b1;
         end
`endif
         case (state)
            ST_IDLE: if (hit) state <= ST_WAIT;
            ST_WAIT: begin
               out_data  <= fifo_data[pend_q*DATA_BITS +: DATA_BITS];
               out_queue <= pend_q;
               out_valid <= 1'b1;
               state     <= ST_SEND;
            end
            ST_SEND: if (xfer) begin
               out_valid <= 1'b0;
               state     <= hit ? ST_WAIT : ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_wrr_pop_scheduler.sv
// tb_wrr_pop_scheduler -- randomized self-checking bench with a transaction
// level reference model (slot pointer / credit as plain integers, in-flight
// word tracked as a pending record) plus literal sequence expectations.
module tb_wrr_pop_scheduler;

   localparam int QN = 4, DB = 8, TS = 8, WB = 6, QB = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1, enb = 1'b0, out_ready = 1'b0;
   logic [QN*WB-1:0]  pesos = '0;
   logic [TS*QB-1:0]  tabla = 16'hE4E4;
   logic [QN-1:0]     buf_empty = '1;
   logic [QN*DB-1:0]  fifo_data = '0;
   logic [QN-1:0]     pop;
   logic [DB-1:0]     out_data;
   logic              out_valid;
   logic [QB-1:0]     out_queue;

   always #5 clk = ~clk;

   wrr_pop_scheduler dut (
      .clk(clk), .rst(rst), .enb(enb), .pesos(pesos), .tabla(tabla),
      .buf_empty(buf_empty), .fifo_data(fifo_data), .pop(pop),
      .out_data(out_data), .out_valid(out_valid), .out_queue(out_queue),
      .out_ready(out_ready)
   );

   int n_chk = 0, n_pass = 0;
   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
   endtask

   // ---------------- FIFO environment (registered read data) ----------------
   logic [7:0] fm [QN][16];
   int fh [QN] = '{default: 0};
   int fc [QN] = '{default: 0};
   int push_pct [QN] = '{default: 0};

   always @(posedge clk) begin
      for (int i = 0; i < QN; i++) begin
         if (pop[i] && fc[i] > 0) begin
            fifo_data[i*DB +: DB] <= fm[i][fh[i]];
            fh[i] = (fh[i] + 1) % 16;
            fc[i] = fc[i] - 1;
         end
         if (fc[i] < 8 && $urandom_range(99) < push_pct[i]) begin
            fm[i][(fh[i] + fc[i]) % 16] = 8'($urandom);
            fc[i] = fc[i] + 1;
         end
         buf_empty[i] <= (fc[i] == 0);
      end
   end

   // ---------------- reference model ----------------
   function automatic int wt(input int q);  return int'(pesos[q*WB +: WB]); endfunction
   function automatic int tq(input int s);  return int'(tabla[s*QB +: QB]); endfunction
   function automatic bit ok(input int s);  return wt(tq(s)) != 0 && !buf_empty[tq(s)]; endfunction

   bit m_pend = 0, m_valid = 0, was_valid;
   int m_pq = 0, m_pd = 0, m_data = 0, m_queue = 0, m_ptr = 0, m_cred = 0;
   int found, c, q, cyc = 0;
   logic [QN-1:0] ep;
   bit chk_en = 0;
   int popq_log[$], popt_log[$], xq_log[$];

   always @(negedge clk) begin
      cyc++;
      for (int i = 0; i < QN; i++)
         if (pop[i]) begin popq_log.push_back(i); popt_log.push_back(cyc); end
      if (!rst && enb && out_valid && out_ready) xq_log.push_back(int'(out_queue));
      if (chk_en) begin
         chk("out_valid", int'(out_valid), int'(m_valid));
         chk("out_data", int'(out_data), m_data);
         chk("out_queue", int'(out_queue), m_queue);
      end
      ep = '0;
      if (rst) begin
         m_pend = 0; m_valid = 0; m_data = 0; m_queue = 0;
         m_ptr = 0; m_cred = (wt(tq(0)) - 1) & 63;
      end else if (enb) begin
         if (m_pend) begin
            m_valid = 1; m_data = m_pd; m_queue = m_pq; m_pend = 0;
         end else begin
            was_valid = m_valid;
            if (m_valid && out_ready) m_valid = 0;
            if (!was_valid || out_ready) begin
               found = -1;
`ifdef WRR_WORK_CONSERVING_EN
               for (int k = 0; k < TS; k++)
                  if (found < 0 && ok((m_ptr + k) % TS)) found = (m_ptr + k) % TS;
`else
               if (ok(m_ptr)) found = m_ptr;
`endif
               if (found >= 0) begin
                  q = tq(found);
                  c = (found == m_ptr) ? m_cred : ((wt(q) - 1) & 63);
                  ep[q] = 1'b1; m_pend = 1; m_pq = q; m_pd = int'(fm[q][fh[q]]);
                  if (c == 0) begin
                     m_ptr = (found + 1) % TS; m_cred = (wt(tq(m_ptr)) - 1) & 63;
                  end else begin
                     m_ptr = found; m_cred = c - 1;
                  end
               end
`ifndef WRR_WORK_CONSERVING_EN
               else if (!was_valid) begin
                  m_ptr = (m_ptr + 1) % TS; m_cred = (wt(tq(m_ptr)) - 1) & 63;
               end
`endif
            end
         end
      end
      if (chk_en) chk("pop", int'(pop), int'(ep));
   end

   // ---------------- stimulus ----------------
   task automatic set_w(input int w0, input int w1, input int w2, input int w3);
      pesos = {6'(w3), 6'(w2), 6'(w1), 6'(w0)};
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic reset_pulse();
      rst = 1'b1; tick(2); rst = 1'b0;
   endtask

   int base, base2, d, wi, gap_idx;
   int exp_a[8] = '{0, 1, 2, 3, 0, 1, 2, 3};
   int exp_b[14] = '{0, 0, 0, 1, 1, 2, 3, 0, 0, 0, 1, 1, 2, 3};
   bit seen;

   initial begin
      // Reset and pre-fill all FIFOs.
      set_w(1, 1, 1, 1); tabla = 16'hE4E4;
      push_pct = '{100, 100, 100, 100};
      tick(1); chk_en = 1;
      tick(10);

      // Round robin, unit weights, always ready.
      base = popq_log.size();
      rst = 1'b0; enb = 1'b1; out_ready = 1'b1;
      tick(20);
      chk("pop_count_20cyc", popq_log.size() - base, 10);
      for (int i = 0; i < 8; i++) chk("rr_order", popq_log[base + i], exp_a[i]);

      // Weighted pass, preceded by a reset landing in WAIT.
      set_w(3, 2, 1, 1);
      rst = 1'b1; tick(2);
      rst = 1'b0; tick(1);            // popped, now in WAIT
      rst = 1'b1; tick(1);
      chk("rst_in_wait_valid", int'(out_valid), 0);
      rst = 1'b0;
      base = xq_log.size();
      tick(40);
      for (int i = 0; i < 14; i++) chk("wrr_seq", xq_log[base + i], exp_b[i]);

      // Backpressure in SEND.
      out_ready = 1'b0;
      seen = 0;
      for (int i = 0; i < 20 && !seen; i++) begin tick(1); seen = out_valid; end
      chk("wait_out_valid", int'(seen), 1);
      d = int'(out_data);
      for (int i = 0; i < 5; i++) begin
         tick(1);
         chk("hold_valid", int'(out_valid), 1);
         chk("hold_data", int'(out_data), d);
         chk("hold_no_pop", int'(pop), 0);
      end
      base = xq_log.size();
      out_ready = 1'b1; tick(1);
      chk("release_one_xfer", xq_log.size() - base, 1);
      chk("valid_drop_after_xfer", int'(out_valid), 0);

      // Queue 1 runs dry: slot 1 skip behaviour.
      set_w(1, 1, 1, 1); push_pct = '{100, 0, 100, 100};
      reset_pulse();
      seen = 0;
      for (int i = 0; i < 300 && !seen; i++) begin tick(1); seen = buf_empty[1]; end
      chk("q1_drained", int'(seen), 1);
      tick(20);
      base = popq_log.size();
      tick(30);
      gap_idx = -1;
      for (int i = base; i < popq_log.size() - 1; i++)
         if (gap_idx < 0 && popq_log[i] == 0) gap_idx = i;
      chk("q0_found", int'(gap_idx >= 0), 1);
      if (gap_idx >= 0) begin
         chk("after_q0_queue", popq_log[gap_idx + 1], 2);
`ifdef WRR_WORK_CONSERVING_EN
         chk("skip_gap", popt_log[gap_idx + 1] - popt_log[gap_idx], 2);
`else
         chk("skip_gap", popt_log[gap_idx + 1] - popt_log[gap_idx], 4);
`endif
      end

      // Zero weight on q3, random handshake, enb dropouts.
      set_w(2, 2, 2, 0); push_pct = '{60, 60, 60, 100};
      reset_pulse();
      base = popq_log.size();
      repeat (200) begin
         tick(1);
         enb = ($urandom_range(99) < 85);
         out_ready = ($urandom_range(99) < 60);
      end
      enb = 1'b1;
      tick(3);
      base2 = xq_log.size();
      enb = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(1);
         chk("enb0_no_pop", int'(pop), 0);
      end
      chk("enb0_no_xfer", xq_log.size() - base2, 0);
      enb = 1'b1;
      d = 0;
      for (int i = base; i < popq_log.size(); i++) if (popq_log[i] == 3) d++;
      chk("q3_zero_weight_pops", d, 0);

      // Long random run.
      repeat (3000) begin
         tick(1);
         rst = ($urandom_range(199) == 0);
         enb = ($urandom_range(99) < 85);
         out_ready = ($urandom_range(99) < 70);
         if ($urandom_range(29) == 0) begin
            wi = $urandom_range(QN - 1);
            pesos[wi*WB +: WB] = ($urandom_range(9) == 0) ? 6'd63 : 6'($urandom_range(4));
         end
         if ($urandom_range(149) == 0) tabla = 16'($urandom);
         if ($urandom_range(49) == 0) push_pct[$urandom_range(QN - 1)] = $urandom_range(100);
      end
      rst = 1'b0;
      tick(5);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/wrr_pop_scheduler.md
WRR_POP_SCHEDULER -- requirements
Module: wrr_pop_scheduler

Interface
REQ-001 SHALL have parameter QUEUE_QUANTITY, default 4: number of source FIFOs.
REQ-002 SHALL have parameter DATA_BITS, default 8: FIFO data width.
REQ-003 SHALL have parameter MAX_WEIGHT, default 64: weight range; WB = $clog2(MAX_WEIGHT) bits per weight.
REQ-004 SHALL have parameter TABLE_SIZE, default 8: arbitration table slots; QB = $clog2(QUEUE_QUANTITY).
REQ-005 SHALL have ports: clk  in  1  clock; rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have ports: enb  in  1  scheduler enable; pesos  in  QUEUE_QUANTITY*WB  weight of queue n at bits [(n+1)*WB-1:n*WB].
REQ-007 SHALL have port tabla  in  TABLE_SIZE*QB  queue index of slot s at bits [(s+1)*QB-1:s*QB].
REQ-008 SHALL have ports: buf_empty  in  QUEUE_QUANTITY  per-FIFO empty; fifo_data  in  QUEUE_QUANTITY*DATA_BITS  per-FIFO registered read data.
REQ-009 SHALL have outputs: pop  out  QUEUE_QUANTITY  one-hot read strobe; out_data  out  DATA_BITS; out_valid  out  1; out_queue  out  QB  source of out_data.
REQ-010 SHALL have input out_ready  in  1  downstream accept.

Function
REQ-011 SHALL keep slot pointer ptr (0..TABLE_SIZE-1) and credit counter cred (WB bits); the slot queue is q = tabla[ptr], its weight pesos[q].
REQ-012 SHALL load cred = pesos[q]-1 on entering a slot; each pop from that slot decrements cred; a pop with cred==0 advances ptr.
REQ-013 SHALL wrap ptr from TABLE_SIZE-1 to 0.
REQ-014 SHALL treat a slot whose weight is 0 as empty (skipped; no pop).
REQ-015 SHALL implement FSM IDLE, WAIT, SEND; all transitions gated by enb (enb=0 freezes state, ptr, cred; pop=0; out_valid/out_data hold).
REQ-016 SHALL in IDLE, when slot queue non-empty, assert pop[q] for exactly one cycle and go to WAIT.
REQ-017 SHALL in WAIT capture fifo_data[q] into out_data, q into out_queue, set out_valid next cycle, go to SEND (read latency 1; pop-to-out_valid 2 cycles).
REQ-018 SHALL in SEND hold out_data/out_valid stable until out_valid&&out_ready; on that cycle, if next selected queue is non-empty, pop it concurrently and go to WAIT, else go to IDLE.
REQ-019 SHALL never assert pop to a queue with buf_empty=1 and never more than one pop bit at a time.
REQ-020 SHALL deassert out_valid the cycle after a transfer unless refilled by REQ-018 (max throughput 1 word per 2 cycles).
REQ-021 SHALL use ptr+1 modulo TABLE_SIZE arithmetic and cred subtraction within WB bits, no wider carry.
REQ-022 SHALL sample pesos when a slot is entered; changes mid-slot apply from the next slot.

Reset
REQ-023 SHALL on rst: state=IDLE, ptr=0, cred=pesos[tabla[0]]-1, pop=0, out_valid=0, out_data=0, out_queue=0.
REQ-024 SHALL give rst priority over enb; rst mid-WAIT/SEND discards the in-flight word (popped data lost, no out_valid).

Configuration
REQ-025 SHALL support macro WRR_WORK_CONSERVING_EN.
REQ-026 SHALL with WRR_WORK_CONSERVING_EN defined: in IDLE/SEND select the first slot from ptr (wrapping) with non-empty, non-zero-weight queue in the same cycle, jumping ptr there.
REQ-027 SHALL without the macro: an empty or zero-weight slot costs exactly one idle cycle, then ptr advances by one.

Structure
REQ-028 SHALL place FSM state encoding (IDLE=0, WAIT=1, SEND=2) and default parameter constants in shared package wrr_pkg.
REQ-029 SHALL isolate slot search (ptr, tabla, pesos, buf_empty -> next slot, hit) in sub-module wrr_slot_select.

Verification
REQ-030 SHALL cover: tabla=[0,1,2,3,0,1,2,3], pesos all 1, all FIFOs full, out_ready=1 -> pop order 0,1,2,3,0,... one pop per 2 cycles.
REQ-031 SHALL cover: pesos q0=3,q1=2 others 1 -> out_queue sequence 0,0,0,1,1,2,3 per table pass.
REQ-032 SHALL cover: out_ready=0 for 5 cycles in SEND -> out_data/out_valid stable, no pop; release -> one transfer.
REQ-033 SHALL cover: q1 empty, macro defined -> slot 1 skipped with no idle cycle; macro undefined -> one idle cycle at slot 1.
REQ-034 SHALL cover: ptr=7 with cred==0 pop -> ptr=0; rst asserted in WAIT -> next cycle IDLE, out_valid=0, ptr=0.
REQ-035 SHALL cover: enb=0 for 3 cycles mid-slot -> no pop, ptr/cred unchanged; q3 weight 0 -> never popped.
